simple_cpu_core: RTL and testbench
==================================

// Module: simple_cpu_core
// PURPOSE
//   Single-cycle 8-bit processor core (CO224 ISA): fetches one 32-bit instruction per clock via PC,
//   executes on an 8x8-bit register file and an 8-bit ALU, and updates PC.
//   Instruction memory is external (testbench/top); this block has no data memory.
// PARAMETERS
//   NREG   8   number of general registers (3-bit index)
//   DW     8   register/ALU data width
// PORTS
//   CLK          in   1   single system clock, all state updates on rising edge
//   RESET        in   1   asynchronous, active-low reset
//   PC           out  32  byte address of current instruction
//   INSTRUCTION  in   32  instruction word at PC (combinational fetch by the top)
// BEHAVIOUR
//   - Format: OP=[31:24], DEST=[23:16], SRC1=[15:8], SRC2/IMM=[7:0]; register indices use bits [2:0] of each field.
//   - Opcodes:
//     - 0x00 loadi: Rd=IMM
//     - 0x01 mov: Rd=R[src2]
//     - 0x02 add: Rd=R1+R2
//     - 0x03 sub: Rd=R1-R2
//     - 0x04 and: Rd=R1&R2
//     - 0x05 or: Rd=R1|R2
//     - 0x06 j: no write; unconditional branch
//     - 0x07 beq: no write; branch if R[src1]==R[src2]
//   - Arithmetic is 8-bit two's complement, wraps modulo 256; no flags stored.
//   - Branch target = PC+4 + (sext(DEST[7:0]) <<2); offset in instruction words, signed -128..+127.
//   - Non-branch / untaken: PC <= PC+4, 32-bit wrap.
//   - Single cycle: decode, operand read and ALU are combinational from INSTRUCTION.
//     Register write and PC update on the same rising CLK edge.
//     Register read is asynchronous; a write is visible to the next instruction.
//   - Undefined opcodes execute as NOP: PC+4, no register write.
//   - Reset (RESET=0, async): PC=0, all registers=0. Held while low.
//     First instruction at addr 0 executes on the first rising edge after release.
//     Reset mid-program aborts the current instruction; no partial write.
//   - Zero-delay synthesizable RTL. The top's fetch latency (<= half period) must settle before the rising edge.
// CONFIGURATION
//   BNE_EN defined:
//     - adds opcode 0x08 bne: branch (same target formula) if R[src1]!=R[src2]; no register write.
//   BNE_EN undefined:
//     - 0x08 is an undefined opcode (NOP).
// STRUCTURE
//   - Shared package cpu_pkg: opcode localparams (OP_LOADI..OP_BNE), instruction field slice constants, alu_op_t enum (FWD, ADD, AND, OR).
//   - Sub-module reg_file_8x8: 2 async read ports, 1 sync write port with enable, async active-low clear.
//   - ALU, decoder and PC logic stay inline in simple_cpu_core.
// TESTING
//   - Reset: RESET=0 mid-run -> PC=0 and all regs 0 immediately; after release, first fetch from addr 0.
//   - Arithmetic program:
//     - loadi r4,5; loadi r2,9; add r6,r4,r2 -> r6=14
//     - then sub r1,r4,r2 -> r1=0xFC
//     - PC steps 0,4,8,12.
//   - Logic/mov: loadi r0,0xF0; loadi r1,0x3C -> and r2=0x30; or r3=0xFC; mov r5,r3 -> r5=0xFC.
//   - Overflow: loadi r0,0xFF; loadi r1,1; add r2,r0,r1 -> r2=0x00.
//   - Branches:
//     - j with offset +2 at PC=8 -> PC=20.
//     - beq offset -3 at PC=20 with equal regs -> PC=12.
//     - unequal -> PC=24.
//   - BNE_EN build: bne equal -> PC+4; unequal with offset +1 -> PC+8.
//     Without BNE_EN, 0x08 -> PC+4, no reg change.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for simple_cpu_core: opcodes, instruction field positions, ALU operations.
package cpu_pkg;

  localparam int unsigned NREG = 8;
  localparam int unsigned DW   = 8;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned DEST_MSB = 23;
  localparam int unsigned DEST_LSB = 16;
  localparam int unsigned SRC1_MSB = 15;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_MSB = 7;
  localparam int unsigned SRC2_LSB = 0;

  typedef enum logic [1:0] {FWD, ADD, AND, OR} alu_op_t;

endpackage

// File: rtl/simple_cpu_core_if.sv
// Instruction fetch bus: the core drives the PC, the memory side returns the word at that PC.
interface simple_cpu_core_if;
  logic [31:0] pc;
  logic [31:0] instruction;

  modport master (output pc, input instruction);
  modport slave  (input pc, output instruction);
endinterface

// File: rtl/reg_file_8x8.sv
// 8x8-bit register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module reg_file_8x8
  import cpu_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [2:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [2:0]    raddr1_i,
  input  logic [2:0]    raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [NREG-1:0][DW-1:0] regs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/simple_cpu_core.sv
// Single-cycle 8-bit CO224 core: combinational decode/ALU from the fetched word, PC and
// register write on the rising edge. Define BNE_EN to add the bne opcode (0x08).
module simple_cpu_core
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  simple_cpu_core_if.master  bus
);

  logic [7:0]    op, dest, src1, src2;
  logic [DW-1:0] rd1, rd2, opb, alu_y;
  logic          we, take_branch;
  alu_op_t       alu_op;
  logic [31:0]   pc_q, pc_d, pc_plus4, br_target;
  logic          unused_src1_hi;

  assign op   = bus.instruction[OP_MSB:OP_LSB];
  assign dest = bus.instruction[DEST_MSB:DEST_LSB];
  assign src1 = bus.instruction[SRC1_MSB:SRC1_LSB];
  assign src2 = bus.instruction[SRC2_MSB:SRC2_LSB];
  assign unused_src1_hi = ^src1[7:3];

  reg_file_8x8 u_rf (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .we_i     (we),
    .waddr_i  (dest[2:0]),
    .wdata_i  (alu_y),
    .raddr1_i (src1[2:0]),
    .raddr2_i (src2[2:0]),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  always_comb begin
    we          = 1'b0;
    take_branch = 1'b0;
    alu_op      = FWD;
    opb         = rd2;
    case (op)
      OP_LOADI: begin we = 1'b1; opb = src2; end
      OP_MOV:   we = 1'b1;
      OP_ADD:   begin we = 1'b1; alu_op = ADD; end
      // Subtraction reuses the adder with the two's-complement negation of R2.
      OP_SUB:   begin we = 1'b1; alu_op = ADD; opb = ~rd2 + 8'd1; end
      OP_AND:   begin we = 1'b1; alu_op = AND; end
      OP_OR:    begin we = 1'b1; alu_op = OR; end
      OP_J:     take_branch = 1'b1;
      OP_BEQ:   take_branch = (rd1 == rd2);
`ifdef BNE_EN
      OP_BNE:   take_branch = (rd1 != rd2);
`endif
      default:  ;
    endcase
  end

  always_comb begin
    alu_y = opb;
    case (alu_op)
      FWD:     alu_y = opb;
      ADD:     alu_y = rd1 + opb;
      AND:     alu_y = rd1 & opb;
      OR:      alu_y = rd1 | opb;
      default: alu_y = opb;
    endcase
  end

  // Branch offset counts instruction words, so it is sign-extended and scaled by 4.
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{22{dest[7]}}, dest, 2'b00};
  assign pc_d      = take_branch ? br_target : pc_plus4;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc = pc_q;

endmodule

// File: tb/tb_simple_cpu_core.sv
// Self-checking bench for simple_cpu_core: ISA-level model compared every cycle, plus
// directed programs with hand-computed results.
module tb_simple_cpu_core;

  typedef logic [7:0][7:0] regs_t;

  logic CLK;
  logic RESET;
  simple_cpu_core_if bus ();

  logic [31:0] imem [64];
  assign bus.instruction = imem[bus.pc[7:2]];

  simple_cpu_core dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] enc(input int op, input int d, input int s1, input int s2);
    return {8'(op), 8'(d), 8'(s1), 8'(s2)};
  endfunction

  // ISA model: next PC and register state from the instruction word.
  function automatic logic [31:0] m_next_pc(input logic [31:0] pc, input regs_t r,
                                            input logic [31:0] w);
    int  off;
    bit  take;
    off  = int'($signed(w[23:16]));
    take = 1'b0;
    case (int'(w[31:24]))
      6: take = 1'b1;
      7: take = (r[w[10:8]] == r[w[2:0]]);
`ifdef BNE_EN
      8: take = (r[w[10:8]] != r[w[2:0]]);
`endif
      default: take = 1'b0;
    endcase
    return take ? pc + 32'd4 + 32'(off * 4) : pc + 32'd4;
  endfunction

  function automatic regs_t m_next_regs(input regs_t r, input logic [31:0] w);
    int a, b;
    a = int'(r[w[10:8]]);
    b = int'(r[w[2:0]]);
    case (int'(w[31:24]))
      0: r[w[18:16]] = w[7:0];
      1: r[w[18:16]] = 8'(b);
      2: r[w[18:16]] = 8'((a + b) % 256);
      3: r[w[18:16]] = 8'((a - b + 256) % 256);
      4: r[w[18:16]] = 8'(a & b);
      5: r[w[18:16]] = 8'(a | b);
      default: ;
    endcase
    return r;
  endfunction

  logic [31:0] m_pc;
  regs_t       m_r;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_pc <= '0;
      m_r  <= '0;
    end else begin
      m_pc <= m_next_pc(m_pc, m_r, imem[m_pc[7:2]]);
      m_r  <= m_next_regs(m_r, imem[m_pc[7:2]]);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: outputs sampled on the falling edge and compared against the model.
  task automatic step_cmp();
    @(posedge CLK);
    @(negedge CLK);
    check("pc_vs_model", 64'(bus.pc), 64'(m_pc));
    check("regs_vs_model", dut.u_rf.regs_q, m_r);
  endtask

  task automatic start_prog();
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("first_fetch_pc", 64'(bus.pc), 64'd0);
  endtask

  int trace[$];

  initial begin
    RESET = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    repeat (2) @(negedge CLK);
    check("reset_pc", 64'(bus.pc), 64'd0);
    check("reset_regs", dut.u_rf.regs_q, 64'd0);

    // Arithmetic
    imem[0] = enc(8'h00, 4, 0, 5);
    imem[1] = enc(8'h00, 2, 0, 9);
    imem[2] = enc(8'h02, 6, 4, 2);
    imem[3] = enc(8'h03, 1, 4, 2);
    release_reset();
    for (int k = 0; k < 4; k++) begin
      step_cmp();
      check("arith_pc_step", 64'(bus.pc), 64'(4 * (k + 1)));
    end
    check("add_r6", 64'(dut.u_rf.regs_q[6]), 64'd14);
    check("sub_r1", 64'(dut.u_rf.regs_q[1]), 64'h0FC);
    check("model_r6", 64'(m_r[6]), 64'd14);

    // Asynchronous reset mid-run, then restart from address 0
    step_cmp();
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("midrst_pc", 64'(bus.pc), 64'd0);
    check("midrst_regs", dut.u_rf.regs_q, 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("held_rst_pc", 64'(bus.pc), 64'd0);
    check("held_rst_regs", dut.u_rf.regs_q, 64'd0);
    release_reset();
    step_cmp();
    check("restart_pc", 64'(bus.pc), 64'd4);
    check("restart_r4", 64'(dut.u_rf.regs_q[4]), 64'd5);

    // Logic and mov
    start_prog();
    imem[0] = enc(8'h00, 0, 0, 8'hF0);
    imem[1] = enc(8'h00, 1, 0, 8'h3C);
    imem[2] = enc(8'h04, 2, 0, 1);
    imem[3] = enc(8'h05, 3, 0, 1);
    imem[4] = enc(8'h01, 5, 0, 3);
    release_reset();
    repeat (5) step_cmp();
    check("and_r2", 64'(dut.u_rf.regs_q[2]), 64'h30);
    check("or_r3", 64'(dut.u_rf.regs_q[3]), 64'hFC);
    check("mov_r5", 64'(dut.u_rf.regs_q[5]), 64'hFC);

    // Overflow wraps modulo 256
    start_prog();
    imem[0] = enc(8'h00, 0, 0, 8'hFF);
    imem[1] = enc(8'h00, 1, 0, 1);
    imem[2] = enc(8'h00, 2, 0, 8'h77);
    imem[3] = enc(8'h02, 2, 0, 1);
    release_reset();
    repeat (4) step_cmp();
    check("ovf_r2", 64'(dut.u_rf.regs_q[2]), 64'h00);

    // Branches, undefined opcode, opcode 0x08
    start_prog();
    imem[0]  = enc(8'h00, 1, 0, 7);
    imem[1]  = enc(8'h00, 2, 0, 7);
    imem[2]  = enc(8'h06, 2, 0, 0);
    imem[3]  = enc(8'h00, 2, 0, 3);
    imem[4]  = enc(8'hFF, 0, 0, 0);
    imem[5]  = enc(8'h07, 8'hFD, 1, 2);
    imem[6]  = enc(8'h08, 1, 1, 2);
    imem[7]  = enc(8'h00, 3, 0, 8'h55);
    imem[8]  = enc(8'h00, 2, 0, 7);
    imem[9]  = enc(8'h08, 1, 1, 2);
`ifdef BNE_EN
    trace = '{4, 8, 20, 12, 16, 20, 24, 32, 36, 40};
`else
    trace = '{4, 8, 20, 12, 16, 20, 24, 28, 32, 36, 40};
`endif
    release_reset();
    foreach (trace[k]) begin
      step_cmp();
      check("branch_trace_pc", 64'(bus.pc), 64'(trace[k]));
    end
`ifdef BNE_EN
    check("bne_skip_r3", 64'(dut.u_rf.regs_q[3]), 64'h00);
`else
    check("op08_nop_r3", 64'(dut.u_rf.regs_q[3]), 64'h55);
`endif
    check("branch_r2", 64'(dut.u_rf.regs_q[2]), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
